gpio_shift_out: RTL

GPIO_SHIFT_OUT -- requirements
Module: gpio_shift_out

---
 rtl/gpio_shift_out.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/gpio_shift_out.sv
// -----------------------------------------------------------------------------
// gpio_shift_out
//
// Serialises the buffered GPIO output word(s) onto an external shift-register
// chain (74HC595 style): MSB first on sdat, clocked by sclk, followed by one
// latch strobe that transfers the chain into its storage registers.
//
// Parameters:
//   size : number of 16-bit words in port_in (N = size*16 bits per frame)
//   div  : system clocks per sclk half-period, 1..65535
//
// Ports:
//   clk     in   system clock, all state updates on the rising edge
//   reset   in   asynchronous, active-high reset
//   port_in in   [N-1:0] parallel word(s) from the gpio_out port_out bus
//   sclk    out  serial shift clock
//   sdat    out  serial data, stable across each sclk low+high pair
//   latch   out  storage-register strobe, active high for div clocks
//   busy    out  high while a frame (shift + latch) is in progress
//
// Configuration macro: GPIO_SHIFT_OUT_CHANGE_DETECT_EN
//   defined   : a frame starts only when port_in differs from the last value
//               sent, so the chain is rewritten only on change.
//   undefined : a frame starts on every IDLE clock, continuously refreshing
//               the chain with exactly one IDLE clock between frames.
//
// Handshake: there is no valid/ready pair; port_in is sampled only on the
// clock that leaves IDLE, and busy marks the window in which it is ignored.
// -----------------------------------------------------------------------------
module gpio_shift_out #(
  parameter int unsigned size = 1,
  parameter int unsigned div  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [size*16-1:0]   port_in,
  output logic                 sclk,
  output logic                 sdat,
  output logic                 latch,
  output logic                 busy
);

  localparam int unsigned N     = size * 16;
  localparam int unsigned DIV_W = (div > 1) ? $clog2(div) : 1;
  localparam int unsigned BIT_W = $clog2(N);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(div - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOW   = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  state_t             state_q,   state_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [N-1:0]       shift_q,   shift_d;
  logic               sclk_q,    sclk_d;
  logic               latch_q,   latch_d;
  logic               busy_q,    busy_d;
  logic               start;
  logic               div_done;

`ifdef GPIO_SHIFT_OUT_CHANGE_DETECT_EN
  logic [N-1:0]       last_q,    last_d;

  assign start = (port_in != last_q);
`else
  assign start = 1'b1;
`endif

  assign div_done = (div_cnt_q == DIV_LAST);

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    sclk_d    = sclk_q;
    latch_d   = latch_q;
    busy_d    = busy_q;
`ifdef GPIO_SHIFT_OUT_CHANGE_DETECT_EN
    last_d    = last_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_LOW;
          shift_d   = port_in;
`ifdef GPIO_SHIFT_OUT_CHANGE_DETECT_EN
          last_d    = port_in;
`endif
          busy_d    = 1'b1;
          sclk_d    = 1'b0;
          latch_d   = 1'b0;
          div_cnt_d = '0;
          bit_cnt_d = '0;
        end
      end

      ST_LOW: begin
        if (div_done) begin
          state_d   = ST_HIGH;
          sclk_d    = 1'b1;
          div_cnt_d = '0;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      ST_HIGH: begin
        if (div_done) begin
          div_cnt_d = '0;
          sclk_d    = 1'b0;
          if (bit_cnt_q == BIT_LAST) begin
            state_d = ST_LATCH;
            latch_d = 1'b1;
          end else begin
            // The next bit appears on the falling sclk edge, so it is stable
            // for the whole following low+high pair.
            state_d   = ST_LOW;
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            shift_d   = {shift_q[N-2:0], 1'b0};
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      ST_LATCH: begin
        if (div_done) begin
          state_d   = ST_IDLE;
          latch_d   = 1'b0;
          busy_d    = 1'b0;
          div_cnt_d = '0;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      sclk_q    <= 1'b0;
      latch_q   <= 1'b0;
      busy_q    <= 1'b0;
`ifdef GPIO_SHIFT_OUT_CHANGE_DETECT_EN
      last_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      sclk_q    <= sclk_d;
      latch_q   <= latch_d;
      busy_q    <= busy_d;
`ifdef GPIO_SHIFT_OUT_CHANGE_DETECT_EN
      last_q    <= last_d;
`endif
    end
  end

  // sdat is the top of the shift register itself: cleared by reset, loaded
  // with port_in[N-1] on start, and held between frames.
  assign sclk  = sclk_q;
  assign sdat  = shift_q[N-1];
  assign latch = latch_q;
  assign busy  = busy_q;

endmodule
